// File: rtl/ysyx_csr_file.sv
// ysyx_csr_file: M/S-mode CSR file and trap unit sitting at the commit stage.
// The read port is combinational; commit writes, traps and xrets update state at the clock edge.
module ysyx_csr_file #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     CNT_W      = 64,
  parameter bit              HAS_SMODE  = 1'b1,
  parameter logic [XLEN-1:0] TVEC_RESET = '0,
  parameter logic [XLEN-1:0] HART_ID    = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [11:0]     raddr_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            rillegal_o,
  input  logic            cmt_valid_i,
  input  logic            cmt_wen_i,
  input  logic [11:0]     cmt_waddr_i,
  input  logic [XLEN-1:0] cmt_wdata_i,
  input  logic [XLEN-1:0] cmt_pc_i,
  input  logic            cmt_ecall_i,
  input  logic            cmt_ebreak_i,
  input  logic            cmt_mret_i,
  input  logic            cmt_sret_i,
  input  logic            cmt_exc_i,
  input  logic [4:0]      cmt_cause_i,
  input  logic [XLEN-1:0] cmt_tval_i,
  input  logic            irq_mtip_i,
  input  logic            irq_msip_i,
  input  logic            irq_meip_i,
  output logic            irq_take_o,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o,
  output logic [1:0]      priv_o
);

  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_S = 2'd1;
  localparam logic [1:0] PRV_M = 2'd3;

  localparam logic [XLEN-1:0] MST_WMASK    = HAS_SMODE ? XLEN'(32'h0002_19AA) : XLEN'(32'h0002_1888);
  localparam logic [XLEN-1:0] SST_MASK     = XLEN'(32'h0000_0122);
  localparam logic [XLEN-1:0] MIE_MASK     = HAS_SMODE ? XLEN'(32'h0000_0AAA) : XLEN'(32'h0000_0888);
  localparam logic [XLEN-1:0] S_INT_MASK   = XLEN'(32'h0000_0222);
  localparam logic [XLEN-1:0] SWIP_MASK    = HAS_SMODE ? XLEN'(32'h0000_0022) : XLEN'(32'h0000_0000);
  localparam logic [XLEN-1:0] MEDELEG_MASK = XLEN'(32'h0000_B3FF);
  localparam logic [XLEN-1:0] MISA = ((XLEN == 32) ? (XLEN'(2'd1) << (XLEN - 2)) : (XLEN'(2'd2) << (XLEN - 2)))
                                   | XLEN'(32'h0010_0100) | (HAS_SMODE ? XLEN'(32'h0004_0000) : XLEN'(32'h0000_0000));

  function automatic logic csr_exists(input logic [11:0] a);
    logic ok;
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hC00, 12'hC01, 12'hC02,
      12'hF11, 12'hF12, 12'hF13, 12'hF14: ok = 1'b1;
      12'h100, 12'h104, 12'h105, 12'h140, 12'h141, 12'h142, 12'h143, 12'h144,
      12'h302, 12'h303: ok = HAS_SMODE;
      12'hB80, 12'hB82, 12'hC80, 12'hC81, 12'hC82: ok = (XLEN == 32);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic csr_access_ok(input logic [11:0] a, input logic [1:0] p, input logic wr);
    return csr_exists(a) && (p >= a[9:8]) && !(wr && (a[11:10] == 2'b11));
  endfunction

  function automatic logic [XLEN-1:0] tvec_legal(input logic [XLEN-1:0] wd);
    return wd[1] ? {wd[XLEN-1:2], 2'b00} : wd;
  endfunction

  function automatic logic [XLEN-1:0] epc_legal(input logic [XLEN-1:0] wd);
    return {wd[XLEN-1:1], 1'b0};
  endfunction

  function automatic logic [1:0] mpp_legal(input logic [1:0] v);
    logic [1:0] r;
    case (v)
      PRV_M:   r = PRV_M;
      PRV_S:   r = HAS_SMODE ? PRV_S : PRV_U;
      default: r = PRV_U;
    endcase
    return r;
  endfunction

  // hi selects the upper 32-bit view (only reachable when XLEN==32)
  function automatic logic [CNT_W-1:0] cnt_merge(input logic [CNT_W-1:0] cur,
                                                 input logic [XLEN-1:0] wd, input logic hi);
    logic [CNT_W-1:0] mask;
    logic [CNT_W-1:0] wide;
    mask = CNT_W'({XLEN{1'b1}});
    wide = CNT_W'(wd);
    if (hi) begin
      mask = mask << 6'd32;
      wide = wide << 6'd32;
    end else begin
      mask = mask;
    end
    return (cur & ~mask) | (wide & mask);
  endfunction

  logic [1:0]       priv_q, priv_d;
  logic [XLEN-1:0]  mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0]  mtval_q, mtval_d, mscratch_q, mscratch_d, medeleg_q, medeleg_d, mideleg_q, mideleg_d;
  logic [XLEN-1:0]  mie_q, mie_d, mip_sw_q, mip_sw_d, stvec_q, stvec_d, sepc_q, sepc_d;
  logic [XLEN-1:0]  scause_q, scause_d, stval_q, stval_d, sscratch_q, sscratch_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic             redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;

  logic [XLEN-1:0]  mip_s, rd_s, tvec_s, trap_pc_s, trap_xcause_s, trap_tval_s, wd_s;
  logic [11:0]      irq_en_s;
  logic [4:0]       irq_cause_s, trap_cause_s;
  logic             exc_any_s, trap_s, xret_s, deleg_s, trap_to_s, csr_we_s;

  // Hardware interrupt lines are mirrored into mip; only SSIP/STIP are software state.
  always_comb begin
    mip_s     = mip_sw_q;
    mip_s[3]  = irq_msip_i;
    mip_s[7]  = irq_mtip_i;
    mip_s[11] = irq_meip_i;
  end

  // Per-source enable against the privilege the interrupt would target, then fixed priority.
  always_comb begin
    irq_en_s = '0;
    for (int i = 0; i < 12; i++) begin
      if (mie_q[i] && mip_s[i]) begin
        if (HAS_SMODE && mideleg_q[i]) begin
          irq_en_s[i] = (priv_q == PRV_U) || ((priv_q == PRV_S) && mstatus_q[1]);
        end else begin
          irq_en_s[i] = (priv_q != PRV_M) || mstatus_q[3];
        end
      end else begin
        irq_en_s[i] = 1'b0;
      end
    end
    if (irq_en_s[11])     irq_cause_s = 5'd11;
    else if (irq_en_s[3]) irq_cause_s = 5'd3;
    else if (irq_en_s[7]) irq_cause_s = 5'd7;
    else if (irq_en_s[9]) irq_cause_s = 5'd9;
    else if (irq_en_s[1]) irq_cause_s = 5'd1;
    else if (irq_en_s[5]) irq_cause_s = 5'd5;
    else                  irq_cause_s = 5'd0;
  end

  assign irq_take_o = |irq_en_s;

  // Trap cause, delegation target and redirect address for this commit.
  always_comb begin
    exc_any_s = cmt_ecall_i | cmt_ebreak_i | cmt_exc_i;
    trap_s    = cmt_valid_i & (irq_take_o | exc_any_s);
    xret_s    = cmt_valid_i & !trap_s & (cmt_mret_i | (HAS_SMODE & cmt_sret_i));
    if (irq_take_o) begin
      trap_cause_s = irq_cause_s;
      trap_tval_s  = '0;
    end else if (cmt_exc_i) begin
      trap_cause_s = cmt_cause_i;
      trap_tval_s  = cmt_tval_i;
    end else if (cmt_ebreak_i) begin
      trap_cause_s = 5'd3;
      trap_tval_s  = cmt_pc_i;
    end else begin
      trap_cause_s = 5'd8 + {3'd0, priv_q};
      trap_tval_s  = '0;
    end
    deleg_s   = irq_take_o ? mideleg_q[trap_cause_s] : medeleg_q[trap_cause_s];
    trap_to_s = HAS_SMODE && (priv_q <= PRV_S) && deleg_s;
    tvec_s    = trap_to_s ? stvec_q : mtvec_q;
    if (irq_take_o && (tvec_s[1:0] == 2'b01)) begin
      trap_pc_s = {tvec_s[XLEN-1:2], 2'b00} + (XLEN'(trap_cause_s) << 2);
    end else begin
      trap_pc_s = {tvec_s[XLEN-1:2], 2'b00};
    end
    trap_xcause_s = XLEN'(trap_cause_s);
    trap_xcause_s[XLEN-1] = irq_take_o;
    csr_we_s = cmt_valid_i && cmt_wen_i && !trap_s && !xret_s && csr_access_ok(cmt_waddr_i, priv_q, 1'b1);
    wd_s     = cmt_wdata_i;
  end

  // Combinational read port.
  always_comb begin
    case (raddr_i)
      12'h300:                   rd_s = mstatus_q;
      12'h100:                   rd_s = mstatus_q & SST_MASK;
      12'h301:                   rd_s = MISA;
      12'h302:                   rd_s = medeleg_q;
      12'h303:                   rd_s = mideleg_q;
      12'h304:                   rd_s = mie_q;
      12'h104:                   rd_s = mie_q & S_INT_MASK;
      12'h344:                   rd_s = mip_s;
      12'h144:                   rd_s = mip_s & S_INT_MASK;
      12'h305:                   rd_s = mtvec_q;
      12'h105:                   rd_s = stvec_q;
      12'h340:                   rd_s = mscratch_q;
      12'h140:                   rd_s = sscratch_q;
      12'h341:                   rd_s = mepc_q;
      12'h141:                   rd_s = sepc_q;
      12'h342:                   rd_s = mcause_q;
      12'h142:                   rd_s = scause_q;
      12'h343:                   rd_s = mtval_q;
      12'h143:                   rd_s = stval_q;
      12'hB00, 12'hC00, 12'hC01: rd_s = XLEN'(mcycle_q);
      12'hB80, 12'hC80, 12'hC81: rd_s = XLEN'(mcycle_q >> 6'd32);
      12'hB02, 12'hC02:          rd_s = XLEN'(minstret_q);
      12'hB82, 12'hC82:          rd_s = XLEN'(minstret_q >> 6'd32);
      12'hF11:                   rd_s = XLEN'(32'h7973_7978);
      12'hF14:                   rd_s = HART_ID;
      default:                   rd_s = '0;
    endcase
  end

  assign rillegal_o = !csr_access_ok(raddr_i, priv_q, 1'b0);
  assign rdata_o    = rillegal_o ? '0 : rd_s;

  // Next-state: trap > xret > CSR write; counters tick unless overwritten.
  always_comb begin
    priv_d = priv_q;       mstatus_d = mstatus_q;   mtvec_d = mtvec_q;       mepc_d = mepc_q;
    mcause_d = mcause_q;   mtval_d = mtval_q;       mscratch_d = mscratch_q; medeleg_d = medeleg_q;
    mideleg_d = mideleg_q; mie_d = mie_q;           mip_sw_d = mip_sw_q;     stvec_d = stvec_q;
    sepc_d = sepc_q;       scause_d = scause_q;     stval_d = stval_q;       sscratch_d = sscratch_q;
    mcycle_d      = mcycle_q + CNT_W'(1'b1);
    minstret_d    = minstret_q + CNT_W'(cmt_valid_i && !trap_s);
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    if (trap_s) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = trap_pc_s;
      if (trap_to_s) begin
        sepc_d = epc_legal(cmt_pc_i); scause_d = trap_xcause_s; stval_d = trap_tval_s;
        mstatus_d[8] = priv_q[0];     mstatus_d[5] = mstatus_q[1];  mstatus_d[1] = 1'b0;
        priv_d = PRV_S;
      end else begin
        mepc_d = epc_legal(cmt_pc_i); mcause_d = trap_xcause_s; mtval_d = trap_tval_s;
        mstatus_d[12:11] = priv_q;    mstatus_d[7] = mstatus_q[3];  mstatus_d[3] = 1'b0;
        priv_d = PRV_M;
      end
    end else if (xret_s) begin
      redir_valid_d = 1'b1;
      if (cmt_mret_i) begin
        priv_d = mstatus_q[12:11];
        mstatus_d[3] = mstatus_q[7];  mstatus_d[7] = 1'b1;  mstatus_d[12:11] = PRV_U;
        mstatus_d[17] = (mstatus_q[12:11] == PRV_M) ? mstatus_q[17] : 1'b0;
        redir_pc_d = mepc_q;
      end else begin
        priv_d = {1'b0, mstatus_q[8]};
        mstatus_d[1] = mstatus_q[5];  mstatus_d[5] = 1'b1;  mstatus_d[8] = 1'b0;  mstatus_d[17] = 1'b0;
        redir_pc_d = sepc_q;
      end
    end else if (csr_we_s) begin
      case (cmt_waddr_i)
        12'h300: begin
          mstatus_d = (mstatus_q & ~MST_WMASK) | (wd_s & MST_WMASK);
          mstatus_d[12:11] = mpp_legal(wd_s[12:11]);
        end
        12'h100: mstatus_d  = (mstatus_q & ~SST_MASK) | (wd_s & SST_MASK);
        12'h302: medeleg_d  = wd_s & MEDELEG_MASK;
        12'h303: mideleg_d  = wd_s & S_INT_MASK;
        12'h304: mie_d      = wd_s & MIE_MASK;
        12'h104: mie_d      = (mie_q & ~S_INT_MASK) | (wd_s & S_INT_MASK);
        12'h344, 12'h144: mip_sw_d = wd_s & SWIP_MASK;
        12'h305: mtvec_d    = tvec_legal(wd_s);
        12'h105: stvec_d    = tvec_legal(wd_s);
        12'h340: mscratch_d = wd_s;
        12'h140: sscratch_d = wd_s;
        12'h341: mepc_d     = epc_legal(wd_s);
        12'h141: sepc_d     = epc_legal(wd_s);
        12'h342: mcause_d   = wd_s;
        12'h142: scause_d   = wd_s;
        12'h343: mtval_d    = wd_s;
        12'h143: stval_d    = wd_s;
        12'hB00: mcycle_d   = cnt_merge(mcycle_q, wd_s, 1'b0);
        12'hB80: mcycle_d   = cnt_merge(mcycle_q, wd_s, 1'b1);
        12'hB02: minstret_d = cnt_merge(minstret_q, wd_s, 1'b0);
        12'hB82: minstret_d = cnt_merge(minstret_q, wd_s, 1'b1);
        default: begin end
      endcase
    end else begin
      redir_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      priv_q <= PRV_M;     mstatus_q <= '0;   mtvec_q <= TVEC_RESET; mepc_q <= '0;
      mcause_q <= '0;      mtval_q <= '0;     mscratch_q <= '0;      medeleg_q <= '0;
      mideleg_q <= '0;     mie_q <= '0;       mip_sw_q <= '0;        stvec_q <= '0;
      sepc_q <= '0;        scause_q <= '0;    stval_q <= '0;         sscratch_q <= '0;
      mcycle_q <= '0;      minstret_q <= '0;  redir_valid_q <= 1'b0; redir_pc_q <= '0;
    end else begin
      priv_q <= priv_d;       mstatus_q <= mstatus_d;   mtvec_q <= mtvec_d;       mepc_q <= mepc_d;
      mcause_q <= mcause_d;   mtval_q <= mtval_d;       mscratch_q <= mscratch_d; medeleg_q <= medeleg_d;
      mideleg_q <= mideleg_d; mie_q <= mie_d;           mip_sw_q <= mip_sw_d;     stvec_q <= stvec_d;
      sepc_q <= sepc_d;       scause_q <= scause_d;     stval_q <= stval_d;       sscratch_q <= sscratch_d;
      mcycle_q <= mcycle_d;   minstret_q <= minstret_d; redir_valid_q <= redir_valid_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign redir_valid_o = redir_valid_q;
  assign redir_pc_o    = redir_pc_q;
  assign priv_o        = priv_q;

endmodule

// File: tb/tb_ysyx_csr_file.sv
// Directed bench for ysyx_csr_file: traps, delegation, xret, interrupts, counters and reset.
module tb_ysyx_csr_file;
  logic        clock, reset;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic        rillegal;
  logic        cmt_valid, cmt_wen, cmt_ecall, cmt_ebreak, cmt_mret, cmt_sret, cmt_exc;
  logic [11:0] cmt_waddr;
  logic [31:0] cmt_wdata, cmt_pc, cmt_tval;
  logic [4:0]  cmt_cause;
  logic        irq_mtip, irq_msip, irq_meip, irq_take, redir_valid;
  logic [31:0] redir_pc;
  logic [1:0]  priv;
  int          n_assert = 0;
  int          n_fail = 0;

  ysyx_csr_file #(.XLEN(32), .CNT_W(64), .HAS_SMODE(1'b1), .TVEC_RESET(32'h0000_0040), .HART_ID(32'h0)) dut (
    .clock(clock), .reset(reset), .raddr_i(raddr), .rdata_o(rdata), .rillegal_o(rillegal),
    .cmt_valid_i(cmt_valid), .cmt_wen_i(cmt_wen), .cmt_waddr_i(cmt_waddr), .cmt_wdata_i(cmt_wdata),
    .cmt_pc_i(cmt_pc), .cmt_ecall_i(cmt_ecall), .cmt_ebreak_i(cmt_ebreak), .cmt_mret_i(cmt_mret),
    .cmt_sret_i(cmt_sret), .cmt_exc_i(cmt_exc), .cmt_cause_i(cmt_cause), .cmt_tval_i(cmt_tval),
    .irq_mtip_i(irq_mtip), .irq_msip_i(irq_msip), .irq_meip_i(irq_meip), .irq_take_o(irq_take),
    .redir_valid_o(redir_valid), .redir_pc_o(redir_pc), .priv_o(priv));

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cmt_valid = 1'b0; cmt_wen = 1'b0; cmt_waddr = 12'h000; cmt_wdata = 32'h0; cmt_pc = 32'h0;
    cmt_ecall = 1'b0; cmt_ebreak = 1'b0; cmt_mret = 1'b0; cmt_sret = 1'b0; cmt_exc = 1'b0;
    cmt_cause = 5'd0; cmt_tval = 32'h0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    cmt_valid = 1'b1; cmt_wen = 1'b1; cmt_waddr = a; cmt_wdata = d;
    step();
    idle();
  endtask

  initial begin
    idle();
    raddr = 12'h000; irq_mtip = 1'b0; irq_msip = 1'b0; irq_meip = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("reset_priv", 32'(priv), 32'd3);
    chk("reset_redir_valid", 32'(redir_valid), 32'd0);
    chk("reset_redir_pc", redir_pc, 32'h0);
    chk("reset_irq_take", 32'(irq_take), 32'd0);
    rd("reset_mtvec", 12'h305, 32'h0000_0040);
    rd("mvendorid", 12'hF11, 32'h7973_7978);
    chk("mvendorid_legal", 32'(rillegal), 32'd0);
    rd("reset_mstatus", 12'h300, 32'h0);
    rd("unimpl_rdata", 12'h7C0, 32'h0);
    chk("unimpl_illegal", 32'(rillegal), 32'd1);
    csr_write(12'hF14, 32'h5);
    rd("mhartid_ro", 12'hF14, 32'h0);

    // M-mode ecall with a same-cycle CSR write that must be cancelled
    csr_write(12'h305, 32'h8000_0000);
    rd("mtvec_wr", 12'h305, 32'h8000_0000);
    cmt_valid = 1'b1; cmt_ecall = 1'b1; cmt_pc = 32'h100;
    cmt_wen = 1'b1; cmt_waddr = 12'h340; cmt_wdata = 32'hDEAD;
    step(); idle();
    chk("ecall_redir_valid", 32'(redir_valid), 32'd1);
    chk("ecall_redir_pc", redir_pc, 32'h8000_0000);
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mepc", 12'h341, 32'h100);
    rd("ecall_wr_cancel", 12'h340, 32'h0);
    rd("ecall_mstatus", 12'h300, 32'h0000_1800);
    step();
    chk("redir_pulse_end", 32'(redir_valid), 32'd0);

    // delegation setup, then mret racing an exception
    csr_write(12'h302, 32'hFFFF_FFFF);
    rd("medeleg_mask", 12'h302, 32'h0000_B3FF);
    csr_write(12'h303, 32'hFFFF_FFFF);
    rd("mideleg_mask", 12'h303, 32'h0000_0222);
    csr_write(12'h105, 32'h200);
    csr_write(12'h300, 32'h80);
    csr_write(12'h341, 32'h204);
    cmt_valid = 1'b1; cmt_mret = 1'b1; cmt_exc = 1'b1; cmt_cause = 5'd2; cmt_tval = 32'h1234; cmt_pc = 32'h300;
    step(); idle();
    chk("exc_vs_mret_priv", 32'(priv), 32'd3);
    chk("exc_vs_mret_pc", redir_pc, 32'h8000_0000);
    rd("exc_mcause", 12'h342, 32'd2);
    rd("exc_mtval", 12'h343, 32'h1234);
    rd("exc_mepc", 12'h341, 32'h300);
    rd("exc_mstatus", 12'h300, 32'h0000_1800);

    csr_write(12'h300, 32'h80);
    csr_write(12'h341, 32'h204);
    cmt_valid = 1'b1; cmt_mret = 1'b1; cmt_pc = 32'h310;
    step(); idle();
    chk("mret_priv", 32'(priv), 32'd0);
    chk("mret_redir_valid", 32'(redir_valid), 32'd1);
    chk("mret_redir_pc", redir_pc, 32'h204);
    rd("u_mstatus_rdata", 12'h300, 32'h0);
    chk("u_mstatus_illegal", 32'(rillegal), 32'd1);

    // U-mode ecall delegated to S, then sret back to U
    cmt_valid = 1'b1; cmt_ecall = 1'b1; cmt_pc = 32'h400;
    step(); idle();
    chk("deleg_priv", 32'(priv), 32'd1);
    chk("deleg_redir_pc", redir_pc, 32'h200);
    rd("deleg_scause", 12'h142, 32'd8);
    rd("deleg_sepc", 12'h141, 32'h400);
    rd("deleg_sstatus", 12'h100, 32'h0);
    cmt_valid = 1'b1; cmt_sret = 1'b1; cmt_pc = 32'h404;
    step(); idle();
    chk("sret_priv", 32'(priv), 32'd0);
    chk("sret_redir_pc", redir_pc, 32'h400);

    // non-delegated exception from U, then ebreak in M
    cmt_valid = 1'b1; cmt_exc = 1'b1; cmt_cause = 5'd10; cmt_tval = 32'h55; cmt_pc = 32'h500;
    step(); idle();
    chk("u_exc_priv", 32'(priv), 32'd3);
    chk("u_exc_redir_pc", redir_pc, 32'h8000_0000);
    rd("u_exc_mcause", 12'h342, 32'd10);
    rd("u_exc_mepc", 12'h341, 32'h500);
    rd("u_exc_mstatus", 12'h300, 32'h0000_00A0);
    cmt_valid = 1'b1; cmt_ebreak = 1'b1; cmt_pc = 32'h600;
    step(); idle();
    rd("ebreak_mcause", 12'h342, 32'd3);
    rd("ebreak_mtval", 12'h343, 32'h600);
    rd("ebreak_mstatus", 12'h300, 32'h0000_1820);

    // vectored machine timer interrupt
    csr_write(12'h305, 32'h1002);
    rd("mtvec_mode2", 12'h305, 32'h1000);
    csr_write(12'h305, 32'h1001);
    csr_write(12'h304, 32'h80);
    irq_mtip = 1'b1;
    #1;
    chk("irq_masked_mie0", 32'(irq_take), 32'd0);
    rd("mip_mtip", 12'h344, 32'h80);
    csr_write(12'h300, 32'h8);
    chk("irq_take", 32'(irq_take), 32'd1);
    cmt_valid = 1'b1; cmt_pc = 32'h700;
    step(); idle();
    chk("irq_redir_valid", 32'(redir_valid), 32'd1);
    chk("irq_redir_pc", redir_pc, 32'h0000_101C);
    rd("irq_mcause", 12'h342, 32'h8000_0007);
    rd("irq_mepc", 12'h341, 32'h700);
    rd("irq_mtval", 12'h343, 32'h0);
    rd("irq_mstatus", 12'h300, 32'h0000_1880);
    chk("irq_take_after", 32'(irq_take), 32'd0);
    irq_mtip = 1'b0;

    // counters: carry across halves and write-over-increment
    csr_write(12'hB80, 32'h2);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    rd("mcycle_lo_set", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycle_hi_set", 12'hB80, 32'h2);
    step();
    rd("mcycle_lo_wrap", 12'hB00, 32'h0);
    rd("mcycle_hi_carry", 12'hB80, 32'h3);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_write(12'hB00, 32'h5);
    rd("mcycle_lo_override", 12'hB00, 32'h5);
    rd("mcycle_hi_hold", 12'hB80, 32'h3);
    rd("cycle_alias", 12'hC00, 32'h5);
    csr_write(12'hB02, 32'd10);
    cmt_valid = 1'b1;
    step(); step(); idle();
    rd("minstret", 12'hB02, 32'd12);
    rd("instret_alias", 12'hC02, 32'd12);
    cmt_valid = 1'b1; cmt_ebreak = 1'b1; cmt_pc = 32'h800;
    step(); idle();
    rd("minstret_trap", 12'hB02, 32'd12);
    rd("ebreak2_mtval", 12'h343, 32'h800);

    // reset asserted on the same edge as a trap
    cmt_valid = 1'b1; cmt_ecall = 1'b1; cmt_pc = 32'h900;
    reset = 1'b1;
    step();
    reset = 1'b0; idle();
    chk("rst_trap_redir_valid", 32'(redir_valid), 32'd0);
    chk("rst_trap_priv", 32'(priv), 32'd3);
    rd("rst_trap_mtvec", 12'h305, 32'h0000_0040);
    rd("rst_trap_mcause", 12'h342, 32'h0);
    rd("rst_trap_mcycle", 12'hB00, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
